sram_rd_arbiter: RTL and testbench
==================================

Name: sram_rd_arbiter

Overview:
- Round-robin arbiter that shares one downstream SRAM-style read channel (toward the AXI bridge) between three read requesters: 0 = icache refill, 1 = dcache refill, 2 = uncached LSU read.
- Allows one outstanding transaction at a time. The grant is held from issue until the response beat returns.
- Supports per-requester abort, used for an icache refill cancelled by a jump.

Parameters:
- N_REQ, 3, number of requesters (fixed at 3 in this revision).
- ADDR_W, 32, request address width.
- TYPE_W, 6, request type/size field width.
- DATA_W, 256, response data width (one cache line, single beat).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-high (despite the name).
- s_req  input  3  per-requester read request; held high until that requester's s_rdy.
- s_addr  input  3*ADDR_W  request addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- s_type  input  3*TYPE_W  request types, packed the same way.
- s_abort  input  3  per-requester cancel of its pending or outstanding read.
- s_rdy  output  3  one-cycle pulse: the request was accepted downstream.
- s_re_valid  output  3  one-cycle pulse: response data is valid for requester i.
- s_re_data  output  DATA_W  response data, broadcast to all requesters.
- m_req  output  1  downstream read request.
- m_addr  output  ADDR_W  downstream address.
- m_type  output  TYPE_W  downstream type.
- m_rdy  input  1  downstream accepts the request (same cycle as m_req).
- m_re_valid  input  1  downstream response valid, single beat.
- m_re_data  input  DATA_W  downstream response data.
- busy  output  1  high whenever the FSM is not in IDLE.
- grant  output  2  index of the current owner; meaningful only while busy.

Behaviour:
- Reset values: FSM = IDLE; ptr = 0; grant = 0; drop = 0.
- All outputs are 0 while rst_n is high, including when reset is asserted mid-transaction. Any in-flight downstream response is forgotten.
- State IDLE:
  - Scan s_req & ~s_abort starting at index ptr, wrapping 2→0.
  - The first hit becomes grant. Latch its addr/type into m_addr/m_type, go to ISSUE.
  - If there is no hit, stay in IDLE.
- State ISSUE:
  - m_req = 1; m_addr/m_type come from the latched registers, which are stable until accepted.
  - If s_abort[grant] is high and m_rdy is low: go to IDLE and set ptr = grant+1 mod 3. No s_rdy pulse.
  - If m_rdy is high: pulse s_rdy[grant] in this same cycle, go to WAIT, set drop = s_abort[grant]. m_rdy has priority over a same-cycle abort.
- State WAIT:
  - m_req = 0.
  - If s_abort[grant] is seen, set drop = 1 (sticky).
  - On m_re_valid, s_re_valid[grant] = ~drop && ~s_abort[grant]. s_re_data = m_re_data combinationally.
  - In the same cycle: ptr = grant+1 mod 3, drop cleared, go to IDLE.
- Latency:
  - A request seen in IDLE at cycle t drives m_req at cycle t+1.
  - m_re_valid at cycle u gives s_re_valid at cycle u.
  - The next arbitration happens in the cycle after u, i.e. one bubble cycle in IDLE.
- Fairness: after a completed or aborted grant to i, requester i has the lowest priority. No requester waits more than 2 transactions.
- Any m_re_valid outside WAIT is ignored.
- s_rdy and s_re_valid are never asserted for more than one requester at a time.
- s_re_data is undefined when no s_re_valid bit is high.

Test Plan:
- Single request: after reset, s_req=3'b010, addr 0x8000_0040, type 6'h05, m_rdy=1 at cycle 1, m_re_valid at cycle 4 with data 0xA5..A5.
  - Expect m_req at cycle 1 with m_addr=0x8000_0040 and m_type=6'h05, s_rdy=3'b010 at cycle 1, s_re_valid=3'b010 at cycle 4 carrying 0xA5..A5, busy low at cycle 5.
- All three requesting continuously from reset, downstream always ready, response 2 cycles after accept.
  - Expect grants in the order 0,1,2,0, each s_rdy one-hot, and no grant repeated while another requester is waiting.
- Abort in ISSUE: requester 0 granted, m_rdy held low 3 cycles, s_abort[0] pulsed at cycle 2.
  - Expect m_req to drop at cycle 3, no s_rdy[0] and no s_re_valid[0], and requester 1 (pending) granted next.
- Abort in WAIT: requester 0 accepted, s_abort[0] pulsed before m_re_valid.
  - Expect m_re_valid consumed with s_re_valid=0, FSM back in IDLE, ptr=1.
- Backpressure: requester 2 with m_rdy low for 10 cycles while addr/type inputs change.
  - Expect m_addr/m_type stable at their latched values, m_req high throughout, and no other requester granted.
- Reset mid-WAIT: rst_n asserted for 1 cycle.
  - Expect all outputs 0 and busy=0 in the following cycle, then a stray m_re_valid ignored.
  - A new request from requester 2 then wins with ptr=0 scan order (0 and 1 idle).

Source files
------------

// File: rtl/sram_rd_arbiter.sv
// Round-robin arbiter sharing one single-outstanding SRAM-style read channel
// among icache refill (0), dcache refill (1) and uncached LSU reads (2).
module sram_rd_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int TYPE_W = 6,
    parameter int DATA_W = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          s_req,
    input  logic [N_REQ*ADDR_W-1:0]   s_addr,
    input  logic [N_REQ*TYPE_W-1:0]   s_type,
    input  logic [N_REQ-1:0]          s_abort,
    output logic [N_REQ-1:0]          s_rdy,
    output logic [N_REQ-1:0]          s_re_valid,
    output logic [DATA_W-1:0]         s_re_data,
    output logic                      m_req,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [TYPE_W-1:0]         m_type,
    input  logic                      m_rdy,
    input  logic                      m_re_valid,
    input  logic [DATA_W-1:0]         m_re_data,
    output logic                      busy,
    output logic [1:0]                grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic                drop_q, drop_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TYPE_W-1:0]   type_q, type_d;

    logic [N_REQ-1:0]    avail;
    logic [N_REQ-1:0]    rdy_s;
    logic [N_REQ-1:0]    rvalid_s;
    logic [1:0]          cand0, cand1, cand2;
    logic [1:0]          win;
    logic                hit;
    logic                abort_g;

    function automatic logic [1:0] inc_idx(input logic [1:0] i);
        case (i)
            2'd0:    inc_idx = 2'd1;
            2'd1:    inc_idx = 2'd2;
            default: inc_idx = 2'd0;
        endcase
    endfunction

    function automatic logic pick_bit(input logic [N_REQ-1:0] v, input logic [1:0] i);
        case (i)
            2'd0:    pick_bit = v[0];
            2'd1:    pick_bit = v[1];
            default: pick_bit = v[2];
        endcase
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] pick_addr(input logic [N_REQ*ADDR_W-1:0] v,
                                                    input logic [1:0] i);
        case (i)
            2'd0:    pick_addr = v[0*ADDR_W +: ADDR_W];
            2'd1:    pick_addr = v[1*ADDR_W +: ADDR_W];
            default: pick_addr = v[2*ADDR_W +: ADDR_W];
        endcase
    endfunction

    function automatic logic [TYPE_W-1:0] pick_type(input logic [N_REQ*TYPE_W-1:0] v,
                                                    input logic [1:0] i);
        case (i)
            2'd0:    pick_type = v[0*TYPE_W +: TYPE_W];
            2'd1:    pick_type = v[1*TYPE_W +: TYPE_W];
            default: pick_type = v[2*TYPE_W +: TYPE_W];
        endcase
    endfunction

    // Round-robin scan from ptr over requesters that are not cancelling.
    always_comb begin
        avail = s_req & ~s_abort;
        cand0 = ptr_q;
        cand1 = inc_idx(cand0);
        cand2 = inc_idx(cand1);
        hit   = |avail;
        if (pick_bit(avail, cand0)) begin
            win = cand0;
        end else if (pick_bit(avail, cand1)) begin
            win = cand1;
        end else begin
            win = cand2;
        end
    end

    // Next-state logic; s_rdy/s_re_valid pulses are combinational with m_rdy/m_re_valid.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        type_d   = type_q;
        rdy_s    = 3'b000;
        rvalid_s = 3'b000;
        abort_g  = pick_bit(s_abort, grant_q);
        case (state_q)
            IDLE: begin
                if (hit) begin
                    grant_d = win;
                    addr_d  = pick_addr(s_addr, win);
                    type_d  = pick_type(s_type, win);
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Acceptance wins over a same-cycle abort; the abort then only drops the data.
                if (m_rdy) begin
                    rdy_s   = onehot(grant_q);
                    drop_d  = abort_g;
                    state_d = WAIT;
                end else if (abort_g) begin
                    ptr_d   = inc_idx(grant_q);
                    state_d = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (m_re_valid) begin
                    if (!drop_q && !abort_g) begin
                        rvalid_s = onehot(grant_q);
                    end else begin
                        rvalid_s = 3'b000;
                    end
                    ptr_d   = inc_idx(grant_q);
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    drop_d  = drop_q | abort_g;
                    state_d = WAIT;
                end
            end
            default: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            drop_q  <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            type_q  <= {TYPE_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, even mid-transaction.
    assign s_rdy      = rst_n ? 3'b000 : rdy_s;
    assign s_re_valid = rst_n ? 3'b000 : rvalid_s;
    assign s_re_data  = rst_n ? {DATA_W{1'b0}} : m_re_data;
    assign m_req      = ~rst_n & (state_q == ISSUE);
    assign m_addr     = rst_n ? {ADDR_W{1'b0}} : addr_q;
    assign m_type     = rst_n ? {TYPE_W{1'b0}} : type_q;
    assign busy       = ~rst_n & (state_q != IDLE);
    assign grant      = rst_n ? 2'd0 : grant_q;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed self-checking bench for sram_rd_arbiter: single read, round-robin,
// aborts in ISSUE and WAIT, backpressure and reset mid-transaction.
module tb_sram_rd_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 32;
    localparam int TYPE_W = 6;
    localparam int DATA_W = 256;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        s_req;
    logic [N_REQ*ADDR_W-1:0] s_addr;
    logic [N_REQ*TYPE_W-1:0] s_type;
    logic [N_REQ-1:0]        s_abort;
    logic [N_REQ-1:0]        s_rdy;
    logic [N_REQ-1:0]        s_re_valid;
    logic [DATA_W-1:0]       s_re_data;
    logic                    m_req;
    logic [ADDR_W-1:0]       m_addr;
    logic [TYPE_W-1:0]       m_type;
    logic                    m_rdy;
    logic                    m_re_valid;
    logic [DATA_W-1:0]       m_re_data;
    logic                    busy;
    logic [1:0]              grant;

    int total = 0;
    int bad   = 0;

    sram_rd_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .TYPE_W(TYPE_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req), .s_addr(s_addr), .s_type(s_type), .s_abort(s_abort),
        .s_rdy(s_rdy), .s_re_valid(s_re_valid), .s_re_data(s_re_data),
        .m_req(m_req), .m_addr(m_addr), .m_type(m_type), .m_rdy(m_rdy),
        .m_re_valid(m_re_valid), .m_re_data(m_re_data),
        .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s_req      = 3'b000;
        s_abort    = 3'b000;
        s_addr     = {(N_REQ*ADDR_W){1'b0}};
        s_type     = {(N_REQ*TYPE_W){1'b0}};
        m_rdy      = 1'b0;
        m_re_valid = 1'b0;
        m_re_data  = {DATA_W{1'b0}};
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        clear_inputs();
        step();
        step();
        rst_n = 1'b0;
    endtask

    logic [2:0]  exp_oh;
    int          n_acc;
    int          acc_cyc;
    logic [31:0] bp_addr;
    logic [5:0]  bp_type;

    initial begin
        // Reset with busy inputs: everything must read zero.
        rst_n = 1'b1;
        clear_inputs();
        s_req      = 3'b111;
        m_re_valid = 1'b1;
        m_re_data  = {8{32'hDEAD_BEEF}};
        step();
        mid();
        chk("rst_s_rdy", s_rdy, 3'b000);
        chk("rst_s_re_valid", s_re_valid, 3'b000);
        chk("rst_s_re_data", s_re_data, 256'd0);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 2'd0);

        // Single request from requester 1.
        do_reset();
        s_req = 3'b010;
        s_addr[1*ADDR_W +: ADDR_W] = 32'h8000_0040;
        s_type[1*TYPE_W +: TYPE_W] = 6'h05;
        mid();
        chk("t1_c0_busy", busy, 1'b0);
        chk("t1_c0_m_req", m_req, 1'b0);
        step();
        m_rdy = 1'b1;
        mid();
        chk("t1_m_req", m_req, 1'b1);
        chk("t1_m_addr", m_addr, 32'h8000_0040);
        chk("t1_m_type", m_type, 6'h05);
        chk("t1_s_rdy", s_rdy, 3'b010);
        chk("t1_grant", grant, 2'd1);
        step();
        m_rdy = 1'b0;
        s_req = 3'b000;
        mid();
        chk("t1_c2_m_req", m_req, 1'b0);
        chk("t1_c2_busy", busy, 1'b1);
        step();
        step();
        m_re_valid = 1'b1;
        m_re_data  = {32{8'hA5}};
        mid();
        chk("t1_s_re_valid", s_re_valid, 3'b010);
        chk("t1_s_re_data", s_re_data, {32{8'hA5}});
        step();
        m_re_valid = 1'b0;
        mid();
        chk("t1_c5_busy", busy, 1'b0);
        chk("t1_c5_s_re_valid", s_re_valid, 3'b000);

        // All three requesting continuously, response two cycles after accept.
        do_reset();
        s_req   = 3'b111;
        m_rdy   = 1'b1;
        n_acc   = 0;
        acc_cyc = -10;
        for (int c = 0; c < 16; c++) begin
            m_re_valid = (c == acc_cyc + 2);
            mid();
            if (s_rdy != 3'b000) begin
                exp_oh = 3'b001 << (n_acc % 3);
                chk("rr_s_rdy", s_rdy, exp_oh);
                acc_cyc = c;
                n_acc++;
            end
            if (m_re_valid) begin
                chk("rr_s_re_valid", s_re_valid, exp_oh);
            end
            step();
        end
        chk("rr_grant_count", n_acc, 4);
        clear_inputs();
        mid();
        chk("rr_idle", busy, 1'b0);

        // Abort while ISSUE is stalled; pending requester 1 must win next.
        do_reset();
        s_req = 3'b011;
        s_addr[0*ADDR_W +: ADDR_W] = 32'h0000_1000;
        s_addr[1*ADDR_W +: ADDR_W] = 32'h0000_2000;
        step();
        mid();
        chk("ab1_m_req_c1", m_req, 1'b1);
        chk("ab1_grant_c1", grant, 2'd0);
        step();
        s_abort = 3'b001;
        mid();
        chk("ab1_s_rdy_c2", s_rdy, 3'b000);
        step();
        s_abort = 3'b000;
        s_req   = 3'b010;
        mid();
        chk("ab1_m_req_c3", m_req, 1'b0);
        chk("ab1_s_rdy_c3", s_rdy, 3'b000);
        step();
        m_rdy = 1'b1;
        mid();
        chk("ab1_grant_next", grant, 2'd1);
        chk("ab1_s_rdy_next", s_rdy, 3'b010);
        chk("ab1_m_addr_next", m_addr, 32'h0000_2000);
        step();
        m_rdy      = 1'b0;
        s_req      = 3'b000;
        m_re_valid = 1'b1;
        mid();
        chk("ab1_s_re_valid", s_re_valid, 3'b010);
        step();
        m_re_valid = 1'b0;

        // Abort while WAIT: response is swallowed and ptr moves to 1.
        do_reset();
        s_req = 3'b001;
        step();
        m_rdy = 1'b1;
        mid();
        chk("ab2_s_rdy", s_rdy, 3'b001);
        step();
        m_rdy   = 1'b0;
        s_req   = 3'b000;
        s_abort = 3'b001;
        step();
        s_abort    = 3'b000;
        m_re_valid = 1'b1;
        m_re_data  = {8{32'h1234_5678}};
        mid();
        chk("ab2_s_re_valid", s_re_valid, 3'b000);
        chk("ab2_busy_c3", busy, 1'b1);
        step();
        m_re_valid = 1'b0;
        s_req      = 3'b011;
        mid();
        chk("ab2_busy_idle", busy, 1'b0);
        step();
        m_rdy = 1'b1;
        mid();
        chk("ab2_ptr1_grant", grant, 2'd1);
        chk("ab2_ptr1_s_rdy", s_rdy, 3'b010);
        step();
        m_rdy = 1'b0;
        s_req = 3'b000;
        step();

        // Backpressure on requester 2 while inputs churn.
        do_reset();
        s_req = 3'b100;
        s_addr[2*ADDR_W +: ADDR_W] = 32'h0000_00A0;
        s_type[2*TYPE_W +: TYPE_W] = 6'h11;
        step();
        for (int c = 1; c <= 10; c++) begin
            bp_addr = $urandom;
            bp_type = 6'($urandom_range(63, 0));
            s_addr  = {bp_addr, bp_addr ^ 32'h5555_5555, bp_addr + 32'd7};
            s_type  = {bp_type, ~bp_type, bp_type ^ 6'h2A};
            if (c >= 2) s_req = 3'b111;
            mid();
            chk("bp_m_req", m_req, 1'b1);
            chk("bp_m_addr", m_addr, 32'h0000_00A0);
            chk("bp_m_type", m_type, 6'h11);
            chk("bp_grant", grant, 2'd2);
            chk("bp_s_rdy_none", s_rdy, 3'b000);
            step();
        end
        m_rdy = 1'b1;
        mid();
        chk("bp_s_rdy", s_rdy, 3'b100);
        step();
        m_rdy  = 1'b0;
        s_req  = 3'b011;
        s_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        step();
        m_re_valid = 1'b1;
        mid();
        chk("bp_s_re_valid", s_re_valid, 3'b100);
        step();
        m_re_valid = 1'b0;
        step();
        mid();
        chk("bp_next_grant", grant, 2'd0);
        chk("bp_next_m_addr", m_addr, 32'h0000_1000);
        chk("bp_next_m_req", m_req, 1'b1);

        // Reset in the middle of WAIT, then a stray response.
        do_reset();
        s_req = 3'b010;
        s_addr[1*ADDR_W +: ADDR_W] = 32'h0000_0B00;
        step();
        m_rdy = 1'b1;
        mid();
        chk("rw_s_rdy", s_rdy, 3'b010);
        step();
        m_rdy = 1'b0;
        s_req = 3'b000;
        rst_n = 1'b1;
        mid();
        chk("rw_rst_busy", busy, 1'b0);
        chk("rw_rst_grant", grant, 2'd0);
        chk("rw_rst_m_addr", m_addr, 32'd0);
        step();
        rst_n      = 1'b0;
        m_re_valid = 1'b1;
        m_re_data  = {32{8'h3C}};
        mid();
        chk("rw_stray_s_re_valid", s_re_valid, 3'b000);
        chk("rw_stray_busy", busy, 1'b0);
        chk("rw_stray_m_req", m_req, 1'b0);
        step();
        m_re_valid = 1'b0;
        s_req      = 3'b100;
        s_addr[2*ADDR_W +: ADDR_W] = 32'h0000_0C00;
        mid();
        chk("rw_post_busy", busy, 1'b0);
        step();
        m_rdy = 1'b1;
        mid();
        chk("rw_new_grant", grant, 2'd2);
        chk("rw_new_s_rdy", s_rdy, 3'b100);
        chk("rw_new_m_addr", m_addr, 32'h0000_0C00);
        step();
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
